// File: rtl/dma_bus_arbiter.sv
// rtl/dma_bus_arbiter.sv - round-robin DMA bus arbiter with CPU handshake and hold limit
//
// Purpose: arbitrates the DMA RX and DMA TX engines for the shared 8-bit system bus,
// requests the bus from the CPU (Dma_Req/Dma_Ack), grants one engine at a time,
// muxes that engine's RAM strobes onto the bus, and caps each grant at MAX_HOLD cycles.
//
// Ports:
//   Clk, Rst                          clock, synchronous active-high reset
//   Rx_Bus_req / Rx_Bus_grant         RX engine request / grant
//   Rx_Address, Rx_Databus, Rx_Cs,
//   Rx_Wena, Rx_Dma_End               RX engine RAM write strobes and end pulse
//   Tx_Bus_req / Tx_Bus_grant         TX engine request / grant
//   Tx_Address, Tx_Cs, Tx_Oen,
//   Tx_Dma_End                        TX engine RAM read strobes and end pulse
//   Dma_Req / Dma_Ack                 bus handshake with the CPU
//   Address, Databus, Cs, Wena, Oen   system bus
//   Rx_Irq, Tx_Irq                    one-cycle transfer-complete pulses
//   Timeout_Err, Err_Clr              sticky hold-limit flag and its clear

module dma_bus_arbiter #(
    parameter int MAX_HOLD = 64,
    parameter int HOLD_W   = 8
) (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        Rx_Bus_req,
    output logic        Rx_Bus_grant,
    input  logic [7:0]  Rx_Address,
    input  logic [7:0]  Rx_Databus,
    input  logic        Rx_Cs,
    input  logic        Rx_Wena,
    input  logic        Rx_Dma_End,
    input  logic        Tx_Bus_req,
    output logic        Tx_Bus_grant,
    input  logic [7:0]  Tx_Address,
    input  logic        Tx_Cs,
    input  logic        Tx_Oen,
    input  logic        Tx_Dma_End,
    output logic        Dma_Req,
    input  logic        Dma_Ack,
    output logic [7:0]  Address,
    output logic [7:0]  Databus,
    output logic        Cs,
    output logic        Wena,
    output logic        Oen,
    output logic        Rx_Irq,
    output logic        Tx_Irq,
    output logic        Timeout_Err,
    input  logic        Err_Clr
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ_CPU,
        S_GRANT_RX,
        S_GRANT_TX,
        S_RELEASE
    } state_t;

    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD - 1);

    state_t              state, state_nxt;
    logic                last_tx, last_tx_nxt;   // 1: TX was served last
    logic [HOLD_W-1:0]   hold_cnt, hold_cnt_nxt;
    logic                rx_irq_q, tx_irq_q, err_q;
    logic                timeout_set;
    logic                rx_wins;
    logic                g_req, g_end, hold_hit;

    // RX wins when it is alone, or when both request and TX was served last.
    assign rx_wins  = Rx_Bus_req && (!Tx_Bus_req || last_tx);
    assign g_req    = (state == S_GRANT_TX) ? Tx_Bus_req : Rx_Bus_req;
    assign g_end    = (state == S_GRANT_TX) ? Tx_Dma_End : Rx_Dma_End;
    assign hold_hit = (hold_cnt == HOLD_LAST);

    always_comb begin
        state_nxt    = state;
        last_tx_nxt  = last_tx;
        hold_cnt_nxt = hold_cnt;
        timeout_set  = 1'b0;
        case (state)
            S_IDLE: begin
                if (Rx_Bus_req || Tx_Bus_req)
                    state_nxt = S_REQ_CPU;
            end
            S_REQ_CPU: begin
                hold_cnt_nxt = '0;
                if (Dma_Ack) begin
                    if (rx_wins)
                        state_nxt = S_GRANT_RX;
                    else if (Tx_Bus_req)
                        state_nxt = S_GRANT_TX;
                    else
                        state_nxt = S_RELEASE;
                end
            end
            S_GRANT_RX, S_GRANT_TX: begin
                hold_cnt_nxt = hold_cnt + 1'b1;
                if (!g_req || g_end || !Dma_Ack || hold_hit) begin
                    state_nxt    = S_RELEASE;
                    last_tx_nxt  = (state == S_GRANT_TX);
                    hold_cnt_nxt = '0;
                    // Only a grant that would otherwise have continued counts as a timeout.
                    timeout_set  = hold_hit && g_req && !g_end && Dma_Ack;
                end
            end
            S_RELEASE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state    <= S_IDLE;
            last_tx  <= 1'b1;
            hold_cnt <= '0;
            rx_irq_q <= 1'b0;
            tx_irq_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state    <= state_nxt;
            last_tx  <= last_tx_nxt;
            hold_cnt <= hold_cnt_nxt;
            rx_irq_q <= (state == S_GRANT_RX) && Rx_Dma_End;
            tx_irq_q <= (state == S_GRANT_TX) && Tx_Dma_End;
            // A new timeout takes priority over a simultaneous clear.
            err_q    <= timeout_set || (err_q && !Err_Clr);
        end
    end

    assign Dma_Req      = (state == S_REQ_CPU) || (state == S_GRANT_RX) || (state == S_GRANT_TX);
    assign Rx_Bus_grant = (state == S_GRANT_RX);
    assign Tx_Bus_grant = (state == S_GRANT_TX);
    assign Rx_Irq       = rx_irq_q;
    assign Tx_Irq       = tx_irq_q;
    assign Timeout_Err  = err_q;

    // Only the granted engine's strobes reach the bus; everything else reads as 0.
    always_comb begin
        Address = 8'h00;
        Databus = 8'h00;
        Cs      = 1'b0;
        Wena    = 1'b0;
        Oen     = 1'b0;
        if (state == S_GRANT_RX) begin
            Address = Rx_Address;
            Databus = Rx_Databus;
            Cs      = Rx_Cs;
            Wena    = Rx_Wena;
        end else if (state == S_GRANT_TX) begin
            Address = Tx_Address;
            Cs      = Tx_Cs;
            Oen     = Tx_Oen;
        end
    end

endmodule
